mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences one single-port unified memory between two requesters: instruction fetch (IF) and the data-memory stage (MEM) of the pipeline.
- Provides a multi-cycle access sequencer with a req/ack handshake, fixed priority and stall outputs for the hazard/pipeline-control logic.
- Sits between PC/IR fetch logic, the MEM-stage datapath and the memory macro.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 21, memory address width.
- MEM_LAT, 2, cycles m_en is held per access (>=1).
- STARVE_MAX, 4, consecutive MEM grants allowed while IF waits (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction word, registered.
- mem_req  in  1  data request; held high until mem_ack.
- mem_rw  in  1  1=read, 0=write (codebase rw convention).
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- mem_ack  out  1  one-cycle pulse: data access complete.
- mem_rdata  out  DATA_W  read data, registered.
- m_en  out  1  memory enable.
- m_rw  out  1  memory direction, 1=read.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid on the last ACCESS cycle.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_mem  out  1  mem_req & ~mem_ack (combinational).
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset, synchronous:
  - state=IDLE.
  - All outputs 0: if_rdata, mem_rdata, m_* and acks.
  - Latched request registers cleared.
- FSM states IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, choose the winner and latch addr/rw/wdata and the owner bit.
  - Load cnt = MEM_LAT-1 and go to ACCESS.
  - With no req, stay in IDLE.
- Arbitration: mem_req beats if_req (older instruction wins).
- ACCESS:
  - m_en=1; m_rw/m_addr/m_wdata are driven from the latched registers only, never from live inputs.
  - Fetch always drives m_rw=1.
  - While cnt!=0, decrement cnt.
  - At cnt==0:
    - For a read, capture m_rdata into the owner's rdata register.
    - Go to DONE.
- DONE:
  - m_en=0; owner's ack=1 for exactly this cycle.
  - Requests are ignored; next state is IDLE.
- Latency: req first seen high in IDLE at cycle T gives ACCESS at T+1..T+MEM_LAT and ack at T+MEM_LAT+1. Back-to-back accesses take MEM_LAT+2 cycles each.
- rdata registers update only on read completion of their owner. On a write, mem_rdata holds its previous value.
- Simultaneous requests: MEM is served first. IF stays stalled and is granted on the next IDLE.
- A req that drops before ack, which is a protocol violation, does not abort the access; ack still pulses.
- Reset mid-ACCESS or in DONE:
  - Access aborted, no ack issued.
  - m_en=0 in the cycle after the reset edge.
- stall_* are combinational and deassert in the ack cycle.

Optional Feature:
- Macro: FETCH_STARVE_GUARD_EN.
- Enabled:
  - A 3-bit-or-wider counter counts consecutive MEM grants made while if_req is high.
  - When the count equals STARVE_MAX, the next IDLE arbitration grants IF even if mem_req is high.
  - The counter clears on any IF grant, when if_req is low at arbitration, and on reset.
- Disabled: strict MEM priority; counter logic absent.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x00010 at T, memory returns 0xA5C3 → m_en high T+1..T+2 with m_rw=1 and m_addr=0x00010; if_ack=1 and if_rdata=0xA5C3 at T+3; stall_if high T..T+2.
- Data write: mem_req=1, mem_rw=0, mem_addr=0x0123, mem_wdata=0xBEEF → m_en=1, m_rw=0 for 2 cycles, then mem_ack pulse; mem_rdata unchanged (0 after reset).
- Simultaneous requests: if_req and mem_req both high at T (read, addr 0x0040) → MEM acked at T+3, IF granted at T+4 and acked at T+7; stall_if high T..T+6.
- Reset mid-access: assert reset at T+2 of a fetch → no if_ack; m_en=0 and busy=0 from T+3; the next request completes normally.
- Starve guard (macro on, STARVE_MAX=4): mem_req held continuously with if_req high → exactly 4 mem_ack pulses, then if_ack, then MEM resumes. With the macro off: IF never acked while mem_req stays high.
- Back-to-back fetches: if_req re-asserted with a new address immediately after each ack → one ack every MEM_LAT+2=4 cycles; m_addr tracks the latched address, not live input changes during ACCESS.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequences a single-port unified memory between instruction fetch (IF)
//   and the data-memory stage (MEM). Fixed priority: MEM wins over IF.
//   Each access is IDLE -> ACCESS (MEM_LAT cycles) -> DONE (ack pulse),
//   i.e. MEM_LAT+2 cycles per transaction when back-to-back.
//
//   Optional feature, macro FETCH_STARVE_GUARD_EN:
//     counts consecutive MEM grants made while IF waits; once the count
//     reaches STARVE_MAX the next arbitration goes to IF.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   if_req/if_addr     fetch request and address
//   if_ack/if_rdata    fetch completion pulse and registered read data
//   mem_req/mem_rw     data request, 1=read 0=write
//   mem_addr/mem_wdata data address and write data
//   mem_ack/mem_rdata  data completion pulse and registered read data
//   m_en/m_rw/m_addr/m_wdata/m_rdata   memory macro interface
//   stall_if/stall_mem combinational stalls to pipeline control
//   busy               sequencer not idle
module mem_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 21,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              m_en,
    output logic              m_rw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_rw;
    logic [DATA_W-1:0] lat_wdata;
    logic              owner_mem;   // 1: current access belongs to MEM
    logic              grant_mem;
    logic              any_req;

    assign any_req = if_req | mem_req;

`ifdef FETCH_STARVE_GUARD_EN
    localparam int SC_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

    logic [SC_W-1:0] starve_cnt;
    logic            if_forced;

    assign if_forced = if_req & (starve_cnt == SC_W'(STARVE_MAX));
    assign grant_mem = mem_req & ~if_forced;

    // Only MEM grants that leave IF waiting advance the count; any IF grant
    // or an arbitration with IF idle restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (if_req && grant_mem)
                starve_cnt <= starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
        end
    end
`else
    assign grant_mem = mem_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_rw    <= 1'b0;
            lat_wdata <= '0;
            owner_mem <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_mem <= grant_mem;
                        lat_addr  <= grant_mem ? mem_addr  : if_addr;
                        lat_rw    <= grant_mem ? mem_rw    : 1'b1;
                        lat_wdata <= grant_mem ? mem_wdata : '0;
                        cnt       <= CNT_W'(MEM_LAT - 1);
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (lat_rw) begin
                        if (owner_mem)
                            mem_rdata <= m_rdata;
                        else
                            if_rdata  <= m_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        m_en      = 1'b0;
        m_rw      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        if_ack    = 1'b0;
        mem_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                m_en    = 1'b1;
                m_rw    = lat_rw;
                m_addr  = lat_addr;
                m_wdata = lat_wdata;
                if (cnt == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                if_ack    = ~owner_mem;
                mem_ack   = owner_mem;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_if  = if_req  & ~if_ack;
    assign stall_mem = mem_req & ~mem_ack;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (DATA_W=16, ADDR_W=21, MEM_LAT=2,
//   STARVE_MAX=4). The memory model returns m_addr[15:0] ^ 16'hA5D3 while
//   m_en is high, so e.g. address 0x00010 reads back 0xA5C3.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [20:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        mem_req;
    logic        mem_rw;
    logic [20:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        m_en;
    logic        m_rw;
    logic [20:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [20:0] b2b_addr [3] = '{21'h00100, 21'h00200, 21'h00300};
    logic [15:0] b2b_data [3] = '{16'hA4D3, 16'hA7D3, 16'hA6D3};

    mem_port_arbiter #(
        .DATA_W(16),
        .ADDR_W(21),
        .MEM_LAT(2),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    always #5 clk = ~clk;

    assign m_rdata = m_en ? (m_addr[15:0] ^ 16'hA5D3) : 16'h0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_rw = 1'b0; mem_addr = '0; mem_wdata = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_m_en", m_en, 0);
        chk("rst_m_rw", m_rw, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_mem_ack", mem_ack, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);

        // Single fetch
        reset = 1'b0; if_req = 1'b1; if_addr = 21'h00010; #1;
        chk("f_T_stall", stall_if, 1);
        chk("f_T_busy", busy, 0);
        tick();
        chk("f_T1_m_en", m_en, 1);
        chk("f_T1_m_rw", m_rw, 1);
        chk("f_T1_m_addr", m_addr, 21'h00010);
        chk("f_T1_ack", if_ack, 0);
        chk("f_T1_stall", stall_if, 1);
        tick();
        chk("f_T2_m_en", m_en, 1);
        chk("f_T2_stall", stall_if, 1);
        tick();
        chk("f_T3_ack", if_ack, 1);
        chk("f_T3_rdata", if_rdata, 16'hA5C3);
        chk("f_T3_stall", stall_if, 0);
        chk("f_T3_m_en", m_en, 0);
        chk("f_T3_busy", busy, 1);
        if_req = 1'b0;
        tick();
        chk("f_T4_ack", if_ack, 0);
        chk("f_T4_busy", busy, 0);

        // Data write; live inputs change during ACCESS
        mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 21'h00123; mem_wdata = 16'hBEEF; #1;
        chk("w_T_stall", stall_mem, 1);
        tick();
        chk("w_T1_m_en", m_en, 1);
        chk("w_T1_m_rw", m_rw, 0);
        chk("w_T1_m_addr", m_addr, 21'h00123);
        chk("w_T1_m_wdata", m_wdata, 16'hBEEF);
        mem_addr = 21'h1FFFF; mem_wdata = 16'h0000; #1;
        tick();
        chk("w_T2_m_addr", m_addr, 21'h00123);
        chk("w_T2_m_wdata", m_wdata, 16'hBEEF);
        chk("w_T2_m_rw", m_rw, 0);
        tick();
        chk("w_T3_ack", mem_ack, 1);
        chk("w_T3_if_ack", if_ack, 0);
        chk("w_T3_stall", stall_mem, 0);
        chk("w_T3_rdata", mem_rdata, 0);
        mem_req = 1'b0;
        tick();

        // Simultaneous requests: MEM read first, then IF
        if_req = 1'b1; if_addr = 21'h00300;
        mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 21'h00040; #1;
        tick();
        chk("s_T1_m_addr", m_addr, 21'h00040);
        chk("s_T1_m_rw", m_rw, 1);
        tick();
        tick();
        chk("s_T3_mem_ack", mem_ack, 1);
        chk("s_T3_mem_rdata", mem_rdata, 16'hA593);
        chk("s_T3_if_ack", if_ack, 0);
        chk("s_T3_stall_if", stall_if, 1);
        mem_req = 1'b0;
        tick();
        chk("s_T4_busy", busy, 0);
        chk("s_T4_stall_if", stall_if, 1);
        tick();
        chk("s_T5_m_addr", m_addr, 21'h00300);
        tick();
        chk("s_T6_stall_if", stall_if, 1);
        tick();
        chk("s_T7_if_ack", if_ack, 1);
        chk("s_T7_if_rdata", if_rdata, 16'hA6D3);
        chk("s_T7_stall_if", stall_if, 0);
        if_req = 1'b0;
        tick();

        // Write whose request drops mid-access still completes
        mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 21'h00055; mem_wdata = 16'h1234; #1;
        tick();
        chk("d_T1_m_wdata", m_wdata, 16'h1234);
        mem_req = 1'b0; #1;
        chk("d_T1_stall", stall_mem, 0);
        tick();
        tick();
        chk("d_T3_ack", mem_ack, 1);
        chk("d_T3_rdata_hold", mem_rdata, 16'hA593);
        tick();

        // Reset during ACCESS aborts, next request completes
        if_req = 1'b1; if_addr = 21'h00200; #1;
        tick();
        tick();
        chk("r_T2_m_en", m_en, 1);
        reset = 1'b1;
        tick();
        chk("r_T3_m_en", m_en, 0);
        chk("r_T3_busy", busy, 0);
        chk("r_T3_if_ack", if_ack, 0);
        chk("r_T3_if_rdata", if_rdata, 0);
        chk("r_T3_mem_rdata", mem_rdata, 0);
        reset = 1'b0;
        tick();
        chk("r_T4_m_addr", m_addr, 21'h00200);
        tick();
        chk("r_T5_if_ack", if_ack, 0);
        tick();
        chk("r_T6_if_ack", if_ack, 1);
        chk("r_T6_if_rdata", if_rdata, 16'hA7D3);
        if_req = 1'b0;
        tick();

        // Back-to-back fetches with live address scrambled during ACCESS
        if_req = 1'b1; if_addr = b2b_addr[0]; #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b_acc1_m_addr", m_addr, b2b_addr[i]);
            chk("b_acc1_ack", if_ack, 0);
            if_addr = 21'h1FFFF; #1;
            tick();
            chk("b_acc2_m_addr", m_addr, b2b_addr[i]);
            tick();
            chk("b_done_ack", if_ack, 1);
            chk("b_done_rdata", if_rdata, b2b_data[i]);
            if (i < 2) if_addr = b2b_addr[i + 1];
            else       if_req = 1'b0;
            tick();
            chk("b_idle_ack", if_ack, 0);
        end

        // MEM held continuously while IF waits
        if_req = 1'b1; if_addr = 21'h00010;
        mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 21'h00040; #1;
        for (int k = 0; k < 6; k++) begin
            logic exp_if;
`ifdef FETCH_STARVE_GUARD_EN
            exp_if = (k == 4);
`else
            exp_if = 1'b0;
`endif
            tick(); tick(); tick();
            chk("sv_if_ack", if_ack, exp_if);
            chk("sv_mem_ack", mem_ack, !exp_if);
            if (exp_if) chk("sv_if_rdata", if_rdata, 16'hA5C3);
            tick();
        end
        if_req = 1'b0; mem_req = 1'b0;
        tick(); tick(); tick(); tick();
        chk("end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
